// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM generator.
//   PwmWidth    - default width of counter, period and duty
//   pwm_state_e - controller state (StIdle, StRun)
package pwm_pkg;

    localparam int unsigned PwmWidth = 8;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } pwm_state_e;

endpackage

// File: rtl/pwm_gen_if.sv
// pwm_gen_if: control/status bundle of the PWM generator.
//   presc_in    - prescaler clock_out level (sampled in clk_in domain)
//   enable      - run request, level-sensitive
//   period      - last count value (period+1 steps per PWM period)
//   duty        - high steps per period
//   load        - strobe: adopt period/duty at the next period boundary
//   pwm_out     - registered PWM waveform
//   period_done - one-clk pulse on each counter wrap
//   busy        - high while running
// Modports: master drives the controls, slave is the generator.
interface pwm_gen_if
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PwmWidth
);
    logic             presc_in;
    logic             enable;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] duty;
    logic             load;
    logic             pwm_out;
    logic             period_done;
    logic             busy;

    modport master (
        output presc_in, enable, period, duty, load,
        input  pwm_out, period_done, busy
    );

    modport slave (
        input  presc_in, enable, period, duty, load,
        output pwm_out, period_done, busy
    );
endinterface

// File: rtl/rise_detect.sv
// rise_detect: one-clk pulse on each rising edge of a level sampled in clk_in.
//   clk_in - clock
//   reset  - asynchronous, active-high
//   d      - level input
//   pulse  - d high now and low on the previous clk
module rise_detect (
    input  logic clk_in,
    input  logic reset,
    input  logic d,
    output logic pulse
);
    logic d_q;

    // Tracks d continuously so a level already high produces no pulse later.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign pulse = d & ~d_q;
endmodule

// File: rtl/pwm_gen.sv
// pwm_gen: PWM generator stepped by rising edges of a prescaler level.
//   clk_in - clock; all state on its rising edge
//   reset  - asynchronous, active-high
//   bus    - pwm_gen_if slave: presc_in/enable/period/duty/load in,
//            pwm_out/period_done/busy out (all registered)
// period/duty are held in shadow registers; a load stages new values that
// are adopted at the next counter wrap so a period is never cut short.
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH = PwmWidth
) (
    input logic       clk_in,
    input logic       reset,
    pwm_gen_if.slave  bus
);
    pwm_state_e       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] per_sh_q, per_sh_d;
    logic [WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic [WIDTH-1:0] stg_per_q, stg_per_d;
    logic [WIDTH-1:0] stg_duty_q, stg_duty_d;
    logic             pending_q, pending_d;
    logic             pwm_q, pwm_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             step;

    rise_detect u_rise_detect (
        .clk_in (clk_in),
        .reset  (reset),
        .d      (bus.presc_in),
        .pulse  (step)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        per_sh_d   = per_sh_q;
        duty_sh_d  = duty_sh_q;
        stg_per_d  = stg_per_q;
        stg_duty_d = stg_duty_q;
        pending_d  = pending_q;
        pwm_d      = 1'b0;
        done_d     = 1'b0;
        busy_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    state_d   = StRun;
                    per_sh_d  = bus.period;
                    duty_sh_d = bus.duty;
                    cnt_d     = '0;
                    pending_d = 1'b0;
                    busy_d    = 1'b1;
                    pwm_d     = (bus.duty != '0);
                end
            end
            StRun: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    busy_d = 1'b1;
                    if (bus.load) begin
                        stg_per_d  = bus.period;
                        stg_duty_d = bus.duty;
                        pending_d  = 1'b1;
                    end
                    if (step) begin
                        if (cnt_q == per_sh_q) begin
                            cnt_d  = '0;
                            done_d = 1'b1;
                            // A load on the wrap clk wins over older staged values.
                            if (bus.load) begin
                                per_sh_d  = bus.period;
                                duty_sh_d = bus.duty;
                                pending_d = 1'b0;
                            end else if (pending_q) begin
                                per_sh_d  = stg_per_q;
                                duty_sh_d = stg_duty_q;
                                pending_d = 1'b0;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    // Compare against post-update values so pwm_out tracks cnt exactly.
                    pwm_d = (cnt_d < duty_sh_d);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            per_sh_q   <= '0;
            duty_sh_q  <= '0;
            stg_per_q  <= '0;
            stg_duty_q <= '0;
            pending_q  <= 1'b0;
            pwm_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            per_sh_q   <= per_sh_d;
            duty_sh_q  <= duty_sh_d;
            stg_per_q  <= stg_per_d;
            stg_duty_q <= stg_duty_d;
            pending_q  <= pending_d;
            pwm_q      <= pwm_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.pwm_out     = pwm_q;
    assign bus.period_done = done_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: directed, table-driven bench for pwm_gen (WIDTH=8).
module tb_pwm_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;

    pwm_gen_if #(.WIDTH(8)) bus ();

    pwm_gen #(.WIDTH(8)) dut (
        .clk_in (clk),
        .reset  (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       presc;
        logic       ld;
        logic [7:0] per;
        logic [7:0] duty;
        logic [2:0] exp;   // {pwm_out, period_done, busy}
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   errors = 0;
    int   hi_cnt = 0;
    int   done_cnt = 0;
    int   phase = 0;
    bit   auto_presc = 1'b0;
    int   n;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic en, input logic p, input logic ld,
                       input logic [7:0] per, input logic [7:0] duty, input logic [2:0] exp);
        vec_t v;
        v.en = en; v.presc = p; v.ld = ld; v.per = per; v.duty = duty; v.exp = exp;
        vecs.push_back(v);
    endtask

    // One clk; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic cycle();
        if (auto_presc) begin
            bus.presc_in = (phase < 2);
            phase = (phase + 1) % 4;
        end
        @(posedge clk);
        #1;
        if (bus.pwm_out) hi_cnt++;
        if (bus.period_done) done_cnt++;
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) cycle();
    endtask

    // Cycles until period_done, bounded by limit.
    task automatic wait_done(input int limit, output int cnt);
        cnt = 0;
        do begin
            cycle();
            cnt++;
        end while (!bus.period_done && cnt < limit);
    endtask

    // Manual presc steps until one produces period_done, bounded by limit.
    task automatic steps_to_done(input int limit, output int cnt);
        logic d;
        cnt = 0;
        d = 1'b0;
        while (!d && cnt < limit) begin
            bus.presc_in = 1'b1;
            cycle();
            d = bus.period_done;
            bus.presc_in = 1'b0;
            cycle();
            cnt++;
        end
    endtask

    function automatic int outs();
        return {29'd0, bus.pwm_out, bus.period_done, bus.busy};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.presc_in = 1'b0;
        bus.enable   = 1'b0;
        bus.load     = 1'b0;
        bus.period   = 8'd0;
        bus.duty     = 8'd0;

        // Per-clk vectors, presc driven by hand.
        add(0, 0, 0, 2, 1, 3'b000);
        add(1, 0, 0, 2, 1, 3'b101);  // enter RUN, cnt0
        add(1, 1, 0, 2, 1, 3'b001);  // cnt1
        add(1, 0, 0, 2, 1, 3'b001);
        add(1, 1, 0, 2, 1, 3'b001);  // cnt2
        add(1, 0, 0, 2, 1, 3'b001);
        add(1, 1, 0, 2, 1, 3'b111);  // wrap
        add(1, 0, 0, 2, 1, 3'b101);
        add(1, 1, 1, 0, 1, 3'b001);  // load per0/duty1 pending, cnt1
        add(1, 0, 0, 5, 5, 3'b001);
        add(1, 1, 0, 5, 5, 3'b001);  // cnt2
        add(1, 0, 0, 5, 5, 3'b001);
        add(1, 1, 0, 5, 5, 3'b111);  // wrap, staged values adopted
        add(1, 0, 0, 5, 5, 3'b101);
        add(1, 1, 0, 5, 5, 3'b111);  // per_sh=0: every step wraps
        add(1, 0, 0, 5, 5, 3'b101);
        add(1, 1, 0, 5, 5, 3'b111);
        add(0, 0, 0, 5, 5, 3'b000);  // back to IDLE
        add(0, 1, 1, 5, 5, 3'b000);  // load ignored in IDLE
        add(0, 0, 0, 5, 5, 3'b000);
        add(0, 1, 0, 3, 2, 3'b000);  // presc high before entry
        add(1, 1, 0, 3, 2, 3'b101);  // enter, cnt0
        add(1, 1, 0, 3, 2, 3'b101);  // no step: presc already high
        add(1, 0, 0, 3, 2, 3'b101);
        add(1, 1, 0, 3, 2, 3'b101);  // cnt1
        add(1, 0, 0, 3, 2, 3'b101);
        add(1, 1, 0, 3, 2, 3'b001);  // cnt2
        add(1, 0, 0, 3, 2, 3'b001);
        add(1, 1, 0, 3, 2, 3'b001);  // cnt3
        add(1, 0, 0, 3, 2, 3'b001);
        add(1, 1, 0, 3, 2, 3'b111);  // wrap
        add(0, 0, 0, 3, 2, 3'b000);

        // Reset state.
        bus.enable = 1'b1;
        run(2);
        check("reset outputs", outs(), 0);
        rst = 1'b0;
        bus.enable = 1'b0;

        foreach (vecs[i]) begin
            bus.enable   = vecs[i].en;
            bus.presc_in = vecs[i].presc;
            bus.load     = vecs[i].ld;
            bus.period   = vecs[i].per;
            bus.duty     = vecs[i].duty;
            cycle();
            check($sformatf("vec %0d outs", i), outs(), int'(vecs[i].exp));
        end
        bus.load = 1'b0;

        // Steady PWM: period 9, duty 3, one step per 4 clk.
        auto_presc = 1'b1;
        phase = 0;
        bus.period = 8'd9;
        bus.duty   = 8'd3;
        bus.enable = 1'b1;
        wait_done(60, n);
        check("steady first wrap", int'(bus.period_done), 1);
        wait_done(60, n);
        check("steady wrap spacing", n, 40);
        hi_cnt = 0;
        run(40);
        check("steady high clks", hi_cnt, 12);
        check("steady wrap at 40", int'(bus.period_done), 1);

        // Shadow update mid-period; inputs changed after the strobe.
        run(10);
        bus.load   = 1'b1;
        bus.period = 8'd4;
        bus.duty   = 8'd2;
        cycle();
        bus.load   = 1'b0;
        bus.period = 8'd7;
        bus.duty   = 8'd7;
        wait_done(60, n);
        check("old period completes", n, 29);
        wait_done(60, n);
        check("new period length", n, 20);
        hi_cnt = 0;
        run(20);
        check("new period high clks", hi_cnt, 8);
        check("new period wrap", int'(bus.period_done), 1);

        // duty = 0.
        bus.enable = 1'b0;
        cycle();
        bus.enable = 1'b1;
        bus.period = 8'd9;
        bus.duty   = 8'd0;
        cycle();
        hi_cnt = 0;
        done_cnt = 0;
        run(80);
        check("duty0 high clks", hi_cnt, 0);
        check("duty0 wraps", done_cnt, 2);

        // duty > period.
        bus.enable = 1'b0;
        cycle();
        bus.enable = 1'b1;
        bus.duty   = 8'd12;
        cycle();
        hi_cnt = 0;
        run(80);
        check("duty12 high clks", hi_cnt, 80);

        // period = 0.
        bus.enable = 1'b0;
        cycle();
        bus.enable = 1'b1;
        bus.period = 8'd0;
        bus.duty   = 8'd0;
        cycle();
        done_cnt = 0;
        run(40);
        check("period0 wraps", done_cnt, 10);

        // Load coinciding with a wrap.
        auto_presc = 1'b0;
        bus.presc_in = 1'b0;
        bus.enable = 1'b0;
        cycle();
        bus.enable = 1'b1;
        bus.period = 8'd2;
        bus.duty   = 8'd1;
        cycle();
        steps_to_done(2, n);   // cnt 0 -> 2, no wrap yet
        check("pre-coincide no wrap", done_cnt - done_cnt + int'(bus.period_done), 0);
        bus.presc_in = 1'b1;
        bus.load   = 1'b1;
        bus.period = 8'd3;
        bus.duty   = 8'd0;
        cycle();
        check("coincide wrap", int'(bus.period_done), 1);
        check("coincide new duty", int'(bus.pwm_out), 0);
        bus.presc_in = 1'b0;
        bus.load   = 1'b0;
        bus.period = 8'd9;
        bus.duty   = 8'd9;
        cycle();
        hi_cnt = 0;
        steps_to_done(10, n);
        check("coincide new period", n, 4);
        check("coincide stays low", hi_cnt, 0);

        // Enable drop at cnt=5, then restart with current inputs.
        bus.enable = 1'b0;
        cycle();
        bus.enable = 1'b1;
        bus.period = 8'd9;
        bus.duty   = 8'd7;
        cycle();
        for (int i = 0; i < 5; i++) begin
            bus.presc_in = 1'b1;
            cycle();
            bus.presc_in = 1'b0;
            cycle();
        end
        check("cnt5 outs", outs(), 3'b101);
        bus.enable = 1'b0;
        cycle();
        check("drop outs", outs(), 0);
        bus.period = 8'd2;
        bus.duty   = 8'd1;
        bus.enable = 1'b1;
        cycle();
        check("restart outs", outs(), 3'b101);
        steps_to_done(10, n);
        check("restart period", n, 3);

        // Async reset with an update pending.
        bus.load   = 1'b1;
        bus.period = 8'd1;
        bus.duty   = 8'd1;
        cycle();
        bus.load   = 1'b0;
        bus.period = 8'd3;
        bus.duty   = 8'd2;
        for (int i = 0; i < 2; i++) begin
            bus.presc_in = 1'b1;
            cycle();
            bus.presc_in = 1'b0;
            cycle();
        end
        check("pre-reset busy", int'(bus.busy), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async reset outs", outs(), 0);
        cycle();
        check("held reset outs", outs(), 0);
        rst = 1'b0;
        bus.enable = 1'b0;
        run(2);
        check("idle after reset", outs(), 0);
        bus.enable = 1'b1;
        cycle();
        check("post-reset entry", outs(), 3'b101);
        steps_to_done(10, n);
        check("post-reset period", n, 4);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/pwm_gen.md
PWM_GEN -- requirements
Module: pwm_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the bit width of the counter, period and duty.
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port presc_in, input, 1 bit: the prescaler clock_out level, sampled in the clk_in domain; each rising edge is one count step.
REQ-005 SHALL have port enable, input, 1 bit: run request, level-sensitive.
REQ-006 SHALL have port period, input, WIDTH bits: last count value, giving a PWM period of period+1 steps.
REQ-007 SHALL have port duty, input, WIDTH bits: number of high steps per period.
REQ-008 SHALL have port load, input, 1 bit: one-cycle strobe requesting adoption of period/duty at the next period boundary.
REQ-009 SHALL have port pwm_out, output, 1 bit: registered PWM waveform.
REQ-010 SHALL have port period_done, output, 1 bit: one-clk pulse on each counter wrap.
REQ-011 SHALL have port busy, output, 1 bit: high while in RUN.

Function
REQ-012 SHALL generate step = presc_in AND NOT presc_d, where presc_d is presc_in registered one clk earlier; steps are ignored outside RUN.
REQ-013 SHALL implement a two-state FSM: IDLE -> RUN when enable=1; RUN -> IDLE when enable=0, on the next clk edge and regardless of the counter position.
REQ-014 On the IDLE->RUN edge, SHALL copy period/duty directly into shadow registers per_sh/duty_sh, clear cnt and clear the pending flag.
REQ-015 In RUN, on a step with cnt != per_sh, SHALL set cnt to cnt+1.
REQ-016 In RUN, on a step with cnt == per_sh, SHALL set cnt to 0 and pulse period_done high for exactly that one clk.
REQ-017 A load in RUN SHALL set pending and capture period/duty into staging registers; a later load before the wrap overwrites the staging values.
REQ-018 At a wrap with pending=1, SHALL move staging into per_sh/duty_sh and clear pending in the same clk.
REQ-019 SHALL give load precedence when load and a wrap coincide: the new values take effect at that wrap.
REQ-020 SHALL update pwm_out on the same edge as cnt, so pwm_out == (cnt < duty_sh) holds at all times in RUN, using the post-update shadows.
REQ-021 Boundary, duty=0: pwm_out SHALL be constantly 0.
REQ-022 Boundary, duty > per_sh: pwm_out SHALL be constantly 1.
REQ-023 Boundary, per_sh=0: every step SHALL wrap and pulse period_done.
REQ-024 SHALL perform all comparisons unsigned at WIDTH bits; cnt never exceeds per_sh and does not overflow.
REQ-025 In IDLE: cnt=0, pwm_out=0, period_done=0, busy=0, and load is ignored.
REQ-026 SHALL produce no step on the first RUN clk if presc_in was already high before entry, since presc_d tracks presc_in continuously.

Reset
REQ-027 While reset=1, SHALL asynchronously force: state=IDLE, cnt=0, presc_d=0, per_sh=0, duty_sh=0, staging=0, pending=0, pwm_out=0, period_done=0, busy=0.
REQ-028 Reset mid-period SHALL discard pending updates; after release, the block stays in IDLE until enable is sampled at 1.

Structure
REQ-029 SHALL place the FSM state enum (IDLE, RUN) and the WIDTH default constant in shared package pwm_pkg.
REQ-030 SHALL implement edge detection in sub-module rise_detect (ports clk_in, reset, d, pulse), which is reusable for other prescaler consumers.

Verification
REQ-031 Steady PWM: WIDTH=8, period=9, duty=3, presc_in toggling every 2 clk (one step per 4 clk) -> pwm_out high 3 steps / low 7 steps, period_done every 40 clk.
REQ-032 Shadow update: load with period=4, duty=2 mid-period -> old waveform runs to the wrap, then 2-high/3-low from the next period; no glitch.
REQ-033 Boundaries: duty=0 -> pwm_out always 0; duty=12, period=9 -> always 1; period=0 -> period_done on every step.
REQ-034 Coincidence: load asserted on the same clk as a wrap -> new values used from cnt=0 of that period.
REQ-035 Enable drop at cnt=5 -> next clk: busy=0, pwm_out=0, cnt=0; re-enable restarts at cnt=0 with the current inputs.
REQ-036 Async reset pulsed mid-period with pending=1 -> all outputs 0 immediately; after release and enable, the unloaded inputs are used, not the stale staging.
